// File: rtl/lcd_text_pkg.sv
// lcd_text_pkg: shared encodings, ASCII constants and menu strings for the LCD text composer
package lcd_text_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SNAP, S_CONV, S_BUILD, S_PRESENT} state_t;
    localparam logic [3:0] PAGE_MENU = 4'd0;
    localparam logic [3:0] PAGE_ENV  = 4'd1;
    localparam logic [3:0] PAGE_ADC0 = 4'd2;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_QMARK = 8'h3F;
    localparam logic [127:0] BLANK_ROW = {16{CH_SPACE}};
    localparam logic [127:0] MENU_ROW1 [4] = '{"   Cotton       ", "    Woody       ", "   Citrus       ", BLANK_ROW};
    localparam logic [127:0] MENU_ROW2 [4] = '{"  Timer 30min   ", "  Timer 60min   ", "  Timer 120min  ", BLANK_ROW};
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d > 4'd9) ? CH_QMARK : CH_ZERO + {4'd0, d};
    endfunction
    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter with saturation to all nines
// Ports: clk, rst (async, active-low); start_i loads bin_i when idle; busy_o while shifting;
// done_o marks the last shift cycle (bcd_o valid from the next cycle); bcd_o digit i at [4*i +: 4].
module bin2bcd_seq
    import lcd_text_pkg::*;
#(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [IN_W-1:0]       bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);
    // enough digits to hold any IN_W-bit value and never fewer than shown
    localparam int WD = ((IN_W + 2) / 3 > DIGITS) ? (IN_W + 2) / 3 : DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [63:0] MAX = 64'(pow10(DIGITS) - 1);
    logic [4*WD-1:0] bcd_q, adj;
    logic [IN_W-1:0] bin_q;
    logic [CW-1:0]   cnt_q;
    logic            sat_q;
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < WD; i++)
            adj[4*i +: 4] = (bcd_q[4*i +: 4] > 4'd4) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (start_i && !busy_o) begin
            bcd_q <= '0;
            bin_q <= bin_i;
            cnt_q <= CW'(IN_W);
            sat_q <= 64'(bin_i) > MAX;
        end else if (busy_o) begin
            {bcd_q, bin_q} <= {adj, bin_q} << 1;
            cnt_q <= cnt_q - 1'b1;
        end
    end
    assign busy_o = cnt_q != '0;
    assign done_o = cnt_q == CW'(1);
    assign bcd_o  = sat_q ? {DIGITS{4'd9}} : bcd_q[4*DIGITS-1:0];
endmodule

// File: rtl/lcd_text_composer.sv
// lcd_text_composer: paged, registered two-row LCD text builder with valid/ack frame handoff
// Ports: clk, rst (async, active-low); page_next advances the page; btn_LR/btn_UD pick menu
// strings; humidity*/temperature* are DHT11 BCD digits; adc_data packs N_CH samples;
// row1/row2 with frame_valid/frame_ack hand a frame to the LCD driver; page is the page index.
module lcd_text_composer
    import lcd_text_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int REFRESH_MS = 100,
    parameter int N_CH       = 2,
    parameter int ADC_W      = 10,
    parameter int DIGITS     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    page_next,
    input  logic [1:0]              btn_LR,
    input  logic [1:0]              btn_UD,
    input  logic [3:0]              humidity10,
    input  logic [3:0]              humidity0,
    input  logic [3:0]              temperature10,
    input  logic [3:0]              temperature0,
    input  logic [N_CH*ADC_W-1:0]   adc_data,
    output logic [127:0]            row1,
    output logic [127:0]            row2,
    output logic                    frame_valid,
    input  logic                    frame_ack,
    output logic [3:0]              page
);
    localparam int NP    = (N_CH + 1) / 2;
    localparam int TICKS = CLK_HZ / 1000 * REFRESH_MS;
    localparam int AP    = 2 * NP * ADC_W;
    localparam logic [3:0] LAST_PAGE = 4'(1 + NP);
    state_t              state_q;
    logic [3:0]          page_q, page_d, page_s_q;
    logic                pending_q, tick, ch_q, frame_valid_q;
    logic [31:0]         tick_cnt_q;
    logic [1:0]          lr_q, ud_q;
    logic [3:0]          t10_q, t0_q, h10_q, h0_q;
    logic [AP-1:0]       adc_q;
    logic [4:0]          conv_ch;
    logic                conv_start, conv_busy, conv_done;
    logic [4*DIGITS-1:0] bcd, dig0_q;
    logic [127:0]        row1_q, row2_q, row1_d, row2_d;
    function automatic logic [127:0] adc_row(input logic [4:0] k, input logic [4*DIGITS-1:0] d);
        logic [127:0] r = BLANK_ROW;
        if (k < 5'(N_CH)) begin
            r[127 -: 40] = {"CH", CH_ZERO + {3'd0, k}, ": "};
            for (int i = 0; i < DIGITS; i++)
                r[87 - 8*i -: 8] = CH_ZERO + {4'd0, d[4*(DIGITS-1-i) +: 4]};
        end
        return r;
    endfunction
    assign tick       = tick_cnt_q == 32'(TICKS - 1);
    assign page_d     = page_next ? ((page_q == LAST_PAGE) ? PAGE_MENU : page_q + 4'd1) : page_q;
    // channel pair for ADC page p is 2(p-2) and 2(p-2)+1; ch_q picks which one is converting
    assign conv_ch    = {page_s_q - PAGE_ADC0, ch_q};
    assign conv_start = (state_q == S_CONV) && !conv_busy;
    bin2bcd_seq #(.IN_W(ADC_W), .DIGITS(DIGITS)) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (adc_q[32'(conv_ch) * ADC_W +: ADC_W]),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );
    // the second channel's digits are taken straight from the converter during BUILD
    always_comb begin
        row1_d = MENU_ROW1[lr_q];
        row2_d = MENU_ROW2[ud_q];
        if (page_s_q == PAGE_ENV) begin
            row1_d = {"Temp: ", digit_char(t10_q), digit_char(t0_q), "C", {7{CH_SPACE}}};
            row2_d = {"Humi: ", digit_char(h10_q), digit_char(h0_q), "%", {7{CH_SPACE}}};
        end else if (page_s_q >= PAGE_ADC0) begin
            row1_d = adc_row({page_s_q - PAGE_ADC0, 1'b0}, dig0_q);
            row2_d = adc_row({page_s_q - PAGE_ADC0, 1'b1}, bcd);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            page_q        <= PAGE_MENU;
            page_s_q      <= PAGE_MENU;
            pending_q     <= 1'b0;
            tick_cnt_q    <= '0;
            lr_q          <= '0;
            ud_q          <= '0;
            t10_q         <= '0;
            t0_q          <= '0;
            h10_q         <= '0;
            h0_q          <= '0;
            adc_q         <= '0;
            ch_q          <= 1'b0;
            dig0_q        <= '0;
            row1_q        <= BLANK_ROW;
            row2_q        <= BLANK_ROW;
            frame_valid_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            page_q     <= page_d;
            // a new request in the SNAP cycle survives so it is not lost
            pending_q  <= tick || page_next || (pending_q && state_q != S_SNAP);
            case (state_q)
                S_IDLE: if (pending_q) state_q <= S_SNAP;
                S_SNAP: begin
                    page_s_q <= page_q;
                    lr_q     <= btn_LR;
                    ud_q     <= btn_UD;
                    t10_q    <= temperature10;
                    t0_q     <= temperature0;
                    h10_q    <= humidity10;
                    h0_q     <= humidity0;
                    adc_q    <= AP'(adc_data);
                    ch_q     <= 1'b0;
                    state_q  <= (page_q >= PAGE_ADC0) ? S_CONV : S_BUILD;
                end
                S_CONV: begin
                    if (conv_start && ch_q) dig0_q <= bcd;
                    if (conv_done) begin
                        ch_q <= 1'b1;
                        if (ch_q) state_q <= S_BUILD;
                    end
                end
                S_BUILD: begin
                    row1_q        <= row1_d;
                    row2_q        <= row2_d;
                    frame_valid_q <= 1'b1;
                    state_q       <= S_PRESENT;
                end
                S_PRESENT: if (frame_ack) begin
                    frame_valid_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign row1        = row1_q;
    assign row2        = row2_q;
    assign frame_valid = frame_valid_q;
    assign page        = page_q;
endmodule

// File: tb/tb_lcd_text_composer.sv
// tb_lcd_text_composer: directed and randomized checks of two composer instances against a string-level model
module tb_lcd_text_composer;
    localparam int ADC_W = 10;
    localparam logic [127:0] BLANK = {16{8'h20}};
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pn [2] = '{1'b0, 1'b0};
    logic ack [2] = '{1'b0, 1'b0};
    logic [1:0] btn_LR = '0, btn_UD = '0;
    logic [3:0] t10 = '0, t0 = '0, h10 = '0, h0 = '0;
    logic [2*ADC_W-1:0] adc_a = '0;
    logic [3*ADC_W-1:0] adc_b = '0;
    wire [127:0] r1 [2];
    wire [127:0] r2 [2];
    wire         fv [2];
    wire [3:0]   pg [2];
    int n_assert = 0, n_fail = 0;
    int page_m [2] = '{0, 0};
    string MENU1 [4] = '{"   Cotton", "    Woody", "   Citrus", ""};
    string MENU2 [4] = '{"  Timer 30min", "  Timer 60min", "  Timer 120min", ""};

    lcd_text_composer #(.CLK_HZ(1000), .REFRESH_MS(200), .N_CH(2), .ADC_W(ADC_W), .DIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .page_next(pn[0]), .btn_LR(btn_LR), .btn_UD(btn_UD),
        .humidity10(h10), .humidity0(h0), .temperature10(t10), .temperature0(t0),
        .adc_data(adc_a), .row1(r1[0]), .row2(r2[0]), .frame_valid(fv[0]),
        .frame_ack(ack[0]), .page(pg[0]));
    lcd_text_composer #(.CLK_HZ(1000), .REFRESH_MS(200), .N_CH(3), .ADC_W(ADC_W), .DIGITS(3)) dut_b (
        .clk(clk), .rst(rst), .page_next(pn[1]), .btn_LR(btn_LR), .btn_UD(btn_UD),
        .humidity10(h10), .humidity0(h0), .temperature10(t10), .temperature0(t0),
        .adc_data(adc_b), .row1(r1[1]), .row2(r2[1]), .frame_valid(fv[1]),
        .frame_ack(ack[1]), .page(pg[1]));

    always #5 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_row(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] s2r(input string s);
        logic [127:0] r = BLANK;
        for (int i = 0; i < s.len() && i < 16; i++) r[127 - 8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic string bcd_s(input logic [3:0] n);
        return (n > 9) ? "?" : $sformatf("%0d", n);
    endfunction

    function automatic string num_s(input int v, input int d);
        int mx = 10 ** d - 1;
        string s = $sformatf("%0d", (v > mx) ? mx : v);
        while (s.len() < d) s = {"0", s};
        return s;
    endfunction

    function automatic string adc_s(input int u, input int k);
        int v;
        if (k >= (u ? 3 : 2)) return "";
        if (u == 1) v = int'(adc_b[k*ADC_W +: ADC_W]);
        else v = int'(adc_a[k*ADC_W +: ADC_W]);
        return $sformatf("CH%0d: %s", k, num_s(v, u ? 3 : 4));
    endfunction

    task automatic expect_rows(input int u, input int p, output logic [127:0] e1, output logic [127:0] e2);
        if (p == 0) begin
            e1 = s2r(MENU1[btn_LR]);
            e2 = s2r(MENU2[btn_UD]);
        end else if (p == 1) begin
            e1 = s2r({"Temp: ", bcd_s(t10), bcd_s(t0), "C"});
            e2 = s2r({"Humi: ", bcd_s(h10), bcd_s(h0), "%"});
        end else begin
            e1 = s2r(adc_s(u, 2 * (p - 2)));
            e2 = s2r(adc_s(u, 2 * (p - 2) + 1));
        end
    endtask

    function automatic logic [3:0] rnd_bcd();
        return ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    endfunction

    function automatic logic [9:0] rnd_adc();
        return ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom);
    endfunction

    task automatic scramble();
        btn_LR = 2'($urandom);
        btn_UD = 2'($urandom);
        t10 = rnd_bcd();
        t0  = rnd_bcd();
        h10 = rnd_bcd();
        h0  = rnd_bcd();
        for (int k = 0; k < 2; k++) adc_a[k*ADC_W +: ADC_W] = rnd_adc();
        for (int k = 0; k < 3; k++) adc_b[k*ADC_W +: ADC_W] = rnd_adc();
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b0;
        pn = '{1'b0, 1'b0};
        ack = '{1'b0, 1'b0};
        page_m = '{0, 0};
        #1;
        if (check) for (int u = 0; u < 2; u++) begin
            chk_row("reset_row1", r1[u], BLANK);
            chk_row("reset_row2", r2[u], BLANK);
            chk_val("reset_valid", fv[u], 0);
            chk_val("reset_page", pg[u], 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // advance one page on instance u and check page, latency, rows and the ack handshake
    task automatic visit(input int u, input bit scr);
        int last = u ? 3 : 2;
        int n = 0;
        int lat;
        logic [127:0] e1, e2;
        page_m[u] = (page_m[u] == last) ? 0 : page_m[u] + 1;
        expect_rows(u, page_m[u], e1, e2);
        lat = (page_m[u] >= 2) ? 3 + 2 * (ADC_W + 1) : 3;
        pn[u] = 1'b1;
        @(posedge clk);
        #1;
        pn[u] = 1'b0;
        chk_val("page", pg[u], page_m[u]);
        while (fv[u] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (scr && n == 2) scramble();
        end
        chk_val("latency", n, lat);
        chk_row("row1", r1[u], e1);
        chk_row("row2", r2[u], e2);
        ack[u] = 1'b1;
        @(posedge clk);
        #1;
        ack[u] = 1'b0;
        chk_val("valid_drop", fv[u], 0);
    endtask

    initial begin
        logic [127:0] e1, e2;
        int n, bad;
        #23;
        do_reset(1'b1);

        btn_LR = 2'd1; btn_UD = 2'd2;
        visit(0, 1'b0);
        visit(0, 1'b0);
        btn_LR = 2'd1; btn_UD = 2'd2;
        visit(0, 1'b0);
        chk_row("menu_woody", r1[0], s2r("    Woody"));
        btn_LR = 2'd3;
        visit(0, 1'b0);
        visit(0, 1'b0);
        visit(0, 1'b0);
        chk_row("menu_blank", r1[0], BLANK);

        do_reset(1'b0);
        t10 = 4'd2; t0 = 4'd7; h10 = 4'd4; h0 = 4'd5;
        visit(0, 1'b0);
        chk_row("env_temp", r1[0], s2r("Temp: 27C"));
        chk_row("env_humi", r2[0], s2r("Humi: 45%"));
        visit(0, 1'b0);
        visit(0, 1'b0);
        t10 = 4'hC;
        visit(0, 1'b0);
        chk_row("env_qmark", r1[0], s2r("Temp: ?7C"));

        do_reset(1'b0);
        adc_a = {10'd7, 10'd1023};
        adc_b = {10'd0, 10'd7, 10'd1023};
        visit(0, 1'b0);
        visit(0, 1'b0);
        chk_row("adc_ch0", r1[0], s2r("CH0: 1023"));
        chk_row("adc_ch1", r2[0], s2r("CH1: 0007"));
        visit(1, 1'b0);
        visit(1, 1'b0);
        chk_row("adc_sat", r1[1], s2r("CH0: 999"));

        do_reset(1'b0);
        scramble();
        for (int i = 0; i < 4; i++) visit(1, 1'b1);
        chk_val("wrap_page", pg[1], 0);

        do_reset(1'b1);
        visit(0, 1'b0);
        pn[0] = 1'b1;
        @(posedge clk);
        #1;
        pn[0] = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_row("midconv_row1", r1[0], BLANK);
        chk_row("midconv_row2", r2[0], BLANK);
        chk_val("midconv_valid", fv[0], 0);
        chk_val("midconv_page", pg[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        page_m = '{0, 0};
        expect_rows(0, 0, e1, e2);
        n = 0;
        while (fv[0] !== 1'b1 && n < 250) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_val("tick_frame", fv[0], 1);
        chk_row("tick_row1", r1[0], e1);
        chk_row("tick_row2", r2[0], e2);

        do_reset(1'b0);
        t10 = 4'd1; t0 = 4'd2; h10 = 4'd3; h0 = 4'd4;
        page_m[0] = 1;
        expect_rows(0, 1, e1, e2);
        pn[0] = 1'b1;
        @(posedge clk);
        #1;
        pn[0] = 1'b0;
        n = 0;
        while (fv[0] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_val("bp_first", fv[0], 1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (!(fv[0] === 1'b1 && r1[0] === e1 && r2[0] === e2)) bad++;
            if (i == 500) begin
                t10 = 4'd9; t0 = 4'd8; h10 = 4'd7; h0 = 4'd6;
            end
        end
        chk_val("bp_hold_stable", bad, 0);
        expect_rows(0, 1, e1, e2);
        ack[0] = 1'b1;
        @(posedge clk);
        #1;
        ack[0] = 1'b0;
        chk_val("bp_drop", fv[0], 0);
        n = 0;
        while (fv[0] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_val("bp_latency", n, 3);
        chk_row("bp_row1", r1[0], e1);
        chk_row("bp_row2", r2[0], e2);
        ack[0] = 1'b1;
        @(posedge clk);
        #1;
        ack[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (fv[0] === 1'b1) n++;
        end
        chk_val("bp_extra_frames", n, 0);

        for (int it = 0; it < 20; it++) begin
            do_reset(1'b0);
            scramble();
            for (int i = 0; i < 3; i++) visit(0, 1'b1);
            for (int i = 0; i < 4; i++) visit(1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
